// File: rtl/tkws_mem_pkg.sv
// Shared types and helpers for the Tsetlin Machine row-count memory.
package tkws_mem_pkg;

    // Width of the SPI word address bus
    localparam int SPI_AW = 12;

    // SPI readback sequencer states
    typedef enum logic [1:0] {
        RB_IDLE = 2'd0,
        RB_WAIT = 2'd1,
        RB_DATA = 2'd2
    } rb_state_t;

    // True when no address bit at or above bank_aw is set, i.e. the SPI
    // address lands inside one bank.
    function automatic logic spi_addr_in_range(input logic [SPI_AW-1:0] addr,
                                               input int bank_aw);
        logic [SPI_AW-1:0] upper_s;
        upper_s = addr >> bank_aw;
        return (upper_s == 12'd0);
    endfunction

endpackage

// File: rtl/row_cnt_sram_1rw.sv
// One row-count bank: single-port synchronous RAM with registered read data.
// Kept deliberately plain so a foundry macro can replace it one-for-one.
module row_cnt_sram_1rw #(
    parameter  int DEPTH = 2048,
    parameter  int DW    = 6,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem_r [DEPTH];

    // Array write, or read into the output register; dout holds otherwise
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                dout <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/row_cnt_bank_array.sv
// Bank array of per-column ROW counts: N_BANK single-port banks shared by
// PE reads, SPI (broadcast) writes and an SPI readback path for verifying a
// loaded model image. Per-bank priority: SPI write > PE read > readback.
module row_cnt_bank_array
    import tkws_mem_pkg::*;
#(
    parameter  int N_BANK  = 5,
    parameter  int DEPTH   = 2048,
    parameter  int DW      = 6,
    parameter  int OUT_REG = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int SW      = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BANK-1:0] ren,
    input  logic [AW-1:0]     raddr [N_BANK],
    output logic [N_BANK-1:0] rready,
    output logic [DW-1:0]     rdata [N_BANK],
    output logic [N_BANK-1:0] rvalid,
    input  logic [N_BANK-1:0] spi_wen_sync,
    input  logic              spi_bcast,
    input  logic [SPI_AW-1:0] spi_addr,
    input  logic [31:0]       spi_data,
    input  logic              spi_rreq,
    input  logic [SW-1:0]     spi_rsel,
    output logic [31:0]       spi_rdata,
    output logic              spi_rvalid,
    output logic              addr_err
);

    logic              any_wen_s;
    logic              wr_ok_s;
    logic              rb_req_bad_s;
    logic [N_BANK-1:0] wr_hit_s;
    logic [N_BANK-1:0] pe_acc_s;
    logic [N_BANK-1:0] rb_acc_s;
    logic [N_BANK-1:0] we_s;
    logic [N_BANK-1:0] ce_s;
    logic [AW-1:0]     bank_addr_s [N_BANK];
    logic [DW-1:0]     dout_s [N_BANK];
    logic [DW-1:0]     rb_dout_s;

    rb_state_t         rb_state_r;
    rb_state_t         rb_state_s;
    logic [SW-1:0]     rb_sel_r;
    logic [AW-1:0]     rb_addr_r;
    logic              rb_bad_r;
    logic [N_BANK-1:0] rvalid_r;
    logic [DW-1:0]     rhold_r [N_BANK];
    logic [31:0]       spi_rdata_r;
    logic              spi_rvalid_r;
    logic              addr_err_r;

    // Per-bank arbitration: decide who owns each bank this cycle
    always_comb begin
        any_wen_s    = |spi_wen_sync;
        wr_ok_s      = spi_addr_in_range(spi_addr, AW);
        rb_req_bad_s = !wr_ok_s || (32'(spi_rsel) >= 32'(N_BANK));
        for (int i = 0; i < N_BANK; i++) begin
            wr_hit_s[i] = spi_wen_sync[i] || (spi_bcast && any_wen_s);
            pe_acc_s[i] = ren[i] && !wr_hit_s[i];
            rb_acc_s[i] = (rb_state_r == RB_WAIT) && !rb_bad_r &&
                          (rb_sel_r == SW'(i)) && !wr_hit_s[i] && !pe_acc_s[i];
            // An out-of-range write still blocks the PE for that cycle,
            // but never touches the array.
            we_s[i]     = wr_hit_s[i] && wr_ok_s;
            ce_s[i]     = we_s[i] || pe_acc_s[i] || rb_acc_s[i];
            if (we_s[i]) begin
                bank_addr_s[i] = spi_addr[AW-1:0];
            end else if (pe_acc_s[i]) begin
                bank_addr_s[i] = raddr[i];
            end else begin
                bank_addr_s[i] = rb_addr_r;
            end
        end
    end

    assign rready = ~wr_hit_s;

    for (genvar g = 0; g < N_BANK; g++) begin : g_bank
        row_cnt_sram_1rw #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_sram (
            .clk  (clk),
            .ce   (ce_s[g]),
            .we   (we_s[g]),
            .addr (bank_addr_s[g]),
            .din  (spi_data[DW-1:0]),
            .dout (dout_s[g])
        );
    end

    if (DW < 32) begin : g_unused_data
        logic unused_spi_data_s;
        assign unused_spi_data_s = ^spi_data[31:DW];
    end

    // PE read valid pulse plus a copy of the last PE result, so rdata is
    // not disturbed when readback later reuses the bank's output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= {N_BANK{1'b0}};
            for (int i = 0; i < N_BANK; i++) begin
                rhold_r[i] <= {DW{1'b0}};
            end
        end else begin
            rvalid_r <= pe_acc_s;
            for (int i = 0; i < N_BANK; i++) begin
                if (rvalid_r[i]) begin
                    rhold_r[i] <= dout_s[i];
                end else begin
                    rhold_r[i] <= rhold_r[i];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [N_BANK-1:0] rvalid_q_r;

        // Extra pipeline stage on the PE read path
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_q_r <= {N_BANK{1'b0}};
                for (int i = 0; i < N_BANK; i++) begin
                    rdata[i] <= {DW{1'b0}};
                end
            end else begin
                rvalid_q_r <= rvalid_r;
                for (int i = 0; i < N_BANK; i++) begin
                    if (rvalid_r[i]) begin
                        rdata[i] <= dout_s[i];
                    end else begin
                        rdata[i] <= rdata[i];
                    end
                end
            end
        end

        assign rvalid = rvalid_q_r;
    end else begin : g_no_out_reg
        // Fresh RAM data in the valid cycle, held copy afterwards
        always_comb begin
            for (int i = 0; i < N_BANK; i++) begin
                rdata[i] = rvalid_r[i] ? dout_s[i] : rhold_r[i];
            end
        end

        assign rvalid = rvalid_r;
    end

    // Readback next-state logic
    always_comb begin
        rb_state_s = rb_state_r;
        case (rb_state_r)
            RB_IDLE: rb_state_s = spi_rreq ? RB_WAIT : RB_IDLE;
            RB_WAIT: rb_state_s = (rb_bad_r || (|rb_acc_s)) ? RB_DATA : RB_WAIT;
            RB_DATA: rb_state_s = RB_IDLE;
            default: rb_state_s = RB_IDLE;
        endcase
    end

    // Readback state register and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_state_r <= RB_IDLE;
            rb_sel_r   <= {SW{1'b0}};
            rb_addr_r  <= {AW{1'b0}};
            rb_bad_r   <= 1'b0;
        end else begin
            rb_state_r <= rb_state_s;
            if ((rb_state_r == RB_IDLE) && spi_rreq) begin
                rb_sel_r  <= spi_rsel;
                rb_addr_r <= spi_addr[AW-1:0];
                rb_bad_r  <= rb_req_bad_s;
            end else begin
                rb_sel_r  <= rb_sel_r;
                rb_addr_r <= rb_addr_r;
                rb_bad_r  <= rb_bad_r;
            end
        end
    end

    // Select the read data of the bank chosen for readback
    always_comb begin
        rb_dout_s = {DW{1'b0}};
        for (int i = 0; i < N_BANK; i++) begin
            rb_dout_s = (rb_sel_r == SW'(i)) ? dout_s[i] : rb_dout_s;
        end
    end

    // Readback result register, valid pulse and sticky address error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_rdata_r  <= 32'd0;
            spi_rvalid_r <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            spi_rvalid_r <= (rb_state_r == RB_DATA);
            if (rb_state_r == RB_DATA) begin
                spi_rdata_r <= rb_bad_r ? 32'd0 : 32'(rb_dout_s);
            end else begin
                spi_rdata_r <= spi_rdata_r;
            end
            if ((any_wen_s && !wr_ok_s) ||
                ((rb_state_r == RB_IDLE) && spi_rreq && rb_req_bad_s)) begin
                addr_err_r <= 1'b1;
            end else begin
                addr_err_r <= addr_err_r;
            end
        end
    end

    assign spi_rdata  = spi_rdata_r;
    assign spi_rvalid = spi_rvalid_r;
    assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_row_cnt_bank_array.sv
// Directed bench for row_cnt_bank_array with default parameters
// (5 banks, 2048 x 6 bit, no output register).
module tb_row_cnt_bank_array;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ren;
    logic [10:0] raddr [5];
    logic [4:0]  rready;
    logic [5:0]  rdata [5];
    logic [4:0]  rvalid;
    logic [4:0]  spi_wen_sync;
    logic        spi_bcast;
    logic [11:0] spi_addr;
    logic [31:0] spi_data;
    logic        spi_rreq;
    logic [2:0]  spi_rsel;
    logic [31:0] spi_rdata;
    logic        spi_rvalid;
    logic        addr_err;

    int total = 0;
    int bad   = 0;
    bit got;

    row_cnt_bank_array dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ren          (ren),
        .raddr        (raddr),
        .rready       (rready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .spi_wen_sync (spi_wen_sync),
        .spi_bcast    (spi_bcast),
        .spi_addr     (spi_addr),
        .spi_data     (spi_data),
        .spi_rreq     (spi_rreq),
        .spi_rsel     (spi_rsel),
        .spi_rdata    (spi_rdata),
        .spi_rvalid   (spi_rvalid),
        .addr_err     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_spi_rvalid(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (spi_rvalid === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; ren = 5'd0; spi_wen_sync = 5'd0; spi_bcast = 1'b0;
        spi_addr = 12'd0; spi_data = 32'd0; spi_rreq = 1'b0; spi_rsel = 3'd0;
        for (int i = 0; i < 5; i++) raddr[i] = 11'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 5; i++) check("rst_rdata", 32'(rdata[i]), 32'd0);
        check("rst_spi_rdata", spi_rdata, 32'd0);
        check("rst_spi_rvalid", 32'(spi_rvalid), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write bank 2 @0x015 = 0x2A, then PE read
        spi_wen_sync = 5'b00100; spi_addr = 12'h015; spi_data = 32'h2A;
        tick();
        spi_wen_sync = 5'd0; ren = 5'b00100; raddr[2] = 11'h015;
        #1;
        check("wr_rready2", 32'(rready[2]), 32'd1);
        tick();
        ren = 5'd0;
        check("wr_rvalid", 32'(rvalid), 32'h04);
        check("wr_rdata2", 32'(rdata[2]), 32'h2A);
        tick();
        check("wr_rvalid_pulse", 32'(rvalid), 32'd0);
        check("wr_rdata2_hold", 32'(rdata[2]), 32'h2A);

        // Readback of bank 2 @0x015: exactly 3 cycles with no contention
        spi_rreq = 1'b1; spi_rsel = 3'd2; spi_addr = 12'h015;
        tick();
        spi_rreq = 1'b0;
        check("rb_lat1", 32'(spi_rvalid), 32'd0);
        tick();
        check("rb_lat2", 32'(spi_rvalid), 32'd0);
        tick();
        check("rb_valid", 32'(spi_rvalid), 32'd1);
        check("rb_data", spi_rdata, 32'h2A);
        tick();
        check("rb_pulse", 32'(spi_rvalid), 32'd0);

        // Broadcast write of 0x3F at last address 0x7FF
        spi_wen_sync = 5'b00001; spi_bcast = 1'b1; spi_addr = 12'h7FF; spi_data = 32'h3F;
        #1;
        check("bc_rready", 32'(rready), 32'd0);
        tick();
        spi_wen_sync = 5'd0; spi_bcast = 1'b0; ren = 5'b11111;
        for (int i = 0; i < 5; i++) raddr[i] = 11'h7FF;
        #1;
        check("bc_rready_rd", 32'(rready), 32'h1F);
        tick();
        ren = 5'd0;
        check("bc_rvalid", 32'(rvalid), 32'h1F);
        for (int i = 0; i < 5; i++) check("bc_rdata", 32'(rdata[i]), 32'h3F);
        check("bc_addr_err", 32'(addr_err), 32'd0);

        // Collision: SPI write and PE read on bank 1 in the same cycle
        spi_wen_sync = 5'b00010; spi_addr = 12'h005; spi_data = 32'h11;
        tick();
        spi_data = 32'h22; ren = 5'b00011; raddr[0] = 11'h7FF; raddr[1] = 11'h005;
        #1;
        check("col_rready", 32'(rready), 32'h1D);
        tick();
        spi_wen_sync = 5'd0;
        check("col_rvalid", 32'(rvalid), 32'h01);
        check("col_rdata0", 32'(rdata[0]), 32'h3F);
        ren = 5'b00010;
        #1;
        check("col_rready1", 32'(rready[1]), 32'd1);
        tick();
        ren = 5'd0;
        check("col_held_rvalid", 32'(rvalid), 32'h02);
        check("col_held_rdata1", 32'(rdata[1]), 32'h22);

        // Out-of-range write is dropped and flagged
        spi_wen_sync = 5'b00001; spi_addr = 12'h000; spi_data = 32'h15;
        tick();
        spi_addr = 12'h800; spi_data = 32'h3F;
        tick();
        spi_wen_sync = 5'd0;
        check("oor_addr_err", 32'(addr_err), 32'd1);
        ren = 5'b00001; raddr[0] = 11'h000;
        tick();
        ren = 5'd0;
        check("oor_rvalid", 32'(rvalid), 32'h01);
        check("oor_word0", 32'(rdata[0]), 32'h15);

        // Readback with bank select 5 returns zero
        spi_rreq = 1'b1; spi_rsel = 3'd5; spi_addr = 12'h000;
        tick();
        spi_rreq = 1'b0;
        wait_spi_rvalid(8, got);
        check("oor_rb_seen", 32'(got), 32'd1);
        check("oor_rb_data", spi_rdata, 32'd0);

        // Readback contention against continuous PE reads of bank 3
        spi_wen_sync = 5'b01000; spi_addr = 12'h033; spi_data = 32'h1D;
        tick();
        spi_wen_sync = 5'd0;
        for (int k = 0; k < 10; k++) begin
            ren = 5'b01000; raddr[3] = 11'h7FF;
            spi_rreq = (k == 0); spi_rsel = 3'd3; spi_addr = 12'h033;
            tick();
            check("ct_pe_rvalid", 32'(rvalid[3]), 32'd1);
            check("ct_pe_rdata", 32'(rdata[3]), 32'h3F);
            check("ct_no_spi_rvalid", 32'(spi_rvalid), 32'd0);
        end
        ren = 5'd0; spi_rreq = 1'b0;
        wait_spi_rvalid(8, got);
        check("ct_rb_seen", 32'(got), 32'd1);
        check("ct_rb_data", spi_rdata, 32'h1D);

        // Reset right after an accepted read
        ren = 5'b00100; raddr[2] = 11'h015;
        tick();
        ren = 5'd0; rst_n = 1'b0;
        #1;
        check("mr_rvalid", 32'(rvalid), 32'd0);
        for (int i = 0; i < 5; i++) check("mr_rdata", 32'(rdata[i]), 32'd0);
        check("mr_spi_rdata", spi_rdata, 32'd0);
        check("mr_spi_rvalid", 32'(spi_rvalid), 32'd0);
        check("mr_addr_err", 32'(addr_err), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        ren = 5'b01100; raddr[2] = 11'h015; raddr[3] = 11'h033;
        tick();
        ren = 5'd0;
        check("mr_reread_rvalid", 32'(rvalid), 32'h0C);
        check("mr_reread2", 32'(rdata[2]), 32'h2A);
        check("mr_reread3", 32'(rdata[3]), 32'h1D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/row_cnt_bank_array.md
# row_cnt_bank_array

Parametrised successor to the per-column ROW count memory in the Tsetlin Machine accelerator. Holds `N_BANK` independent single-port banks of `DW`-bit row counts, one bank per group of PE columns. Adds three things over the fixed 5-bank, 6-bit version:
- an explicit read handshake with a valid flag;
- an SPI broadcast write mode;
- an arbitrated SPI readback path for post-load verification of the model image.

## Interface
Parameters
- `N_BANK`, 5, number of banks (one per PE-column group).
- `DEPTH`, 2048, words per bank; `AW = $clog2(DEPTH)`.
- `DW`, 6, row-count word width; must be ≤ 32.
- `OUT_REG`, 0, 1 adds an output register stage on the PE read data path.

Ports
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ren`  in  N_BANK  per-bank PE read request.
- `raddr[N_BANK]`  in  AW  per-bank read address.
- `rready`  out  N_BANK  read accepted this cycle when `ren[i] && rready[i]`.
- `rdata[N_BANK]`  out  DW  read data.
- `rvalid`  out  N_BANK  one-cycle pulse qualifying `rdata[i]`.
- `spi_wen_sync`  in  N_BANK  one-hot per-bank SPI write strobe, already synchronised.
- `spi_bcast`  in  1  with any `spi_wen_sync` bit set, the write goes to all banks.
- `spi_addr`  in  12  SPI word address.
- `spi_data`  in  32  SPI write data; bits [DW-1:0] are used.
- `spi_rreq`  in  1  single-cycle readback request pulse.
- `spi_rsel`  in  $clog2(N_BANK)  readback bank select.
- `spi_rdata`  out  32  readback data, zero-extended.
- `spi_rvalid`  out  1  one-cycle pulse qualifying `spi_rdata`.
- `addr_err`  out  1  sticky out-of-range address flag; cleared only by reset.

## Operation
- **Port priority per bank:** SPI write > PE read > SPI readback. Each bank is single-port with one access per cycle.
- `rready[i] = !(spi_wen_sync[i] || (spi_bcast && |spi_wen_sync))`. This is combinational with no dependence on `ren`.
- **PE read:** when accepted, the bank is read at `raddr[i]`. `rdata[i]` holds its last value until the next accepted read.
- **Unaccepted PE read:** the request is ignored. The PE holds `ren`/`raddr` until accepted, and the block does not queue it.
- **SPI write:**
  - Writes go to bank i at `spi_addr[AW-1:0]`, or to all banks when `spi_bcast` is set.
  - If `spi_addr[11:AW]` ≠ 0, the write is dropped and `addr_err` is set.
  - Multiple `spi_wen_sync` bits set without `spi_bcast`: each flagged bank is written.
- **SPI readback FSM**, states `RB_IDLE`, `RB_WAIT`, `RB_DATA`:
  - `RB_IDLE` latches `spi_rsel`/`spi_addr` on `spi_rreq` and goes to `RB_WAIT`.
  - `RB_WAIT` issues the read on the first cycle in which the selected bank has neither an SPI write nor an accepted PE read, then goes to `RB_DATA`.
  - `RB_DATA` drives `spi_rdata` and pulses `spi_rvalid`, then returns to `RB_IDLE`.
  - Out-of-range address or `spi_rsel ≥ N_BANK`: set `addr_err`, return data 0 with `spi_rvalid` after one cycle, and perform no bank access.
  - `spi_rreq` while not in `RB_IDLE` is ignored.
- Memory contents are not reset.

## Timing
- **Reset values:** `rdata` = 0, `rvalid` = 0, `spi_rdata` = 0, `spi_rvalid` = 0, `addr_err` = 0, FSM in `RB_IDLE`. The pipeline register under `OUT_REG` is also cleared.
- **PE read latency:** a read accepted at edge T gives `rvalid` and `rdata` at T+1, or at T+2 with `OUT_REG`=1. Back-to-back accepted reads give one result per cycle.
- **Write visibility:** a write at edge T is visible to any read accepted at T+1 or later.
- **Readback latency:** minimum 3 cycles from `spi_rreq` to `spi_rvalid`. It is unbounded while the PE reads the selected bank continuously. Starvation is acceptable because readback is used only when the core is idle.
- **Reset mid-operation:** in-flight `rvalid` and `spi_rvalid` pulses are suppressed and the FSM returns to `RB_IDLE`.

## Structure
- **Package `tkws_mem_pkg`:** `rb_state_t` enum (`RB_IDLE`, `RB_WAIT`, `RB_DATA`) and the `SPI_AW` = 12 constant.
- **Sub-module `row_cnt_sram_1rw`:** one bank, a parametrised single-port synchronous RAM with `DEPTH`/`DW`, active-high `ce`/`we`, and registered `dout`. It is instantiated `N_BANK` times in a generate loop and can be swapped for a foundry macro.
- **Top level:** holds the per-bank arbitration, the optional output register stage, the readback FSM and `addr_err`.

## Test plan
- **Write/read:** SPI write bank 2, addr 0x015, data 0x2A; next cycle `ren[2]`, `raddr` = 0x015.
  - Required: `rready[2]` = 1, then `rvalid[2]` and `rdata[2]` = 0x2A one cycle later (two cycles with `OUT_REG`=1).
- **Collision:** `spi_wen_sync[1]` and `ren[1]` in the same cycle.
  - Required: `rready[1]` = 0 and no `rvalid[1]`.
  - Other banks' reads complete normally. The held read completes the following cycle with the newly written value.
- **Broadcast:** `spi_bcast` = 1, `spi_wen_sync[0]`, addr 0x7FF, data 0x3F.
  - Required: all banks read 0x3F at 0x7FF (last address, no wrap).
- **Out of range:** SPI write with addr 0x800 (`DEPTH` = 2048).
  - Required: `addr_err` = 1 and the word at 0x000 unchanged.
  - Readback of `spi_rsel` = 5 also returns 0 with `spi_rvalid`.
- **Readback contention:** `spi_rreq` to bank 3 while `ren[3]` is asserted for 10 cycles.
  - Required: `spi_rvalid` only after `ren[3]` drops, `spi_rdata` = the stored value, and PE reads are never delayed.
- **Reset mid-read:** assert `rst_n` low one cycle after an accepted read.
  - Required: no `rvalid` pulse, all outputs at reset values, and memory contents preserved on re-read.
